echo_timer: RTL and testbench
=============================

Name: echo_timer

Overview:
- Parametrised single-channel ultrasonic ranging engine: issues the trigger pulse, waits for the echo, and measures echo high time in prescaled ticks.
- Adds what the previous echo measurement block lacked: input synchroniser, rising-edge qualification, no-echo timeout, counter saturation and a held result with valid/ack handshake.
- Sits between the sensor pins and the distance-computation / display logic.

Parameters:
- CNT_W, 20, width of measured duration `du`.
- TRIG_CYCLES, 1000, trig high time in clk cycles (>=1).
- PRESCALE, 1, clk cycles per duration tick (>=1).
- TIMEOUT, 2500000, max clk cycles in WAIT_RISE before giving up (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a measurement; honoured only in IDLE.
- echo  in  1  raw asynchronous echo from the sensor.
- trig  out  1  trigger pulse to the sensor.
- busy  out  1  high whenever state != IDLE.
- du  out  CNT_W  measured duration in ticks; held while du_valid.
- du_timeout  out  1  qualifies du: no echo edge, or counter saturated.
- du_valid  out  1  result available; high in DONE.
- du_ack  in  1  consumer accepts the result.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - trig, busy, du_valid and du_timeout go to 0; du goes to 0.
  - Synchroniser flops, prescaler, duration and timeout counters all clear.
  - trig drops immediately when rst rises mid-pulse.
- Synchroniser:
  - echo passes through 2 flops giving echo_s, plus one delay flop echo_d.
  - rise = echo_s & ~echo_d.
  - All echo decisions use echo_s, which is 2 cycles of latency.
- States: IDLE, TRIG, WAIT_RISE, MEASURE, DONE.
- IDLE:
  - start=1 goes to TRIG next cycle.
  - Entering TRIG clears du, du_timeout and all counters.
- TRIG:
  - trig=1 for exactly TRIG_CYCLES consecutive cycles; trig is registered.
  - Then goes to WAIT_RISE.
  - echo activity is ignored.
- WAIT_RISE:
  - The timeout counter counts cycles spent in this state.
  - rise goes to MEASURE. echo already high on entry does not count; it must fall and rise again.
  - If TIMEOUT cycles elapse with no rise: go to DONE with du=0 and du_timeout=1.
  - If rise and the last timeout cycle coincide, rise wins.
- MEASURE:
  - Each cycle with echo_s=1 advances the prescaler.
  - The prescaler wraps at PRESCALE-1 and increments the duration count on each wrap.
  - The rise cycle counts as the first high cycle.
  - Result: du = floor(H / PRESCALE), where H = number of clk cycles echo_s was high.
  - echo_s=0: capture du = count, du_timeout=0, go to DONE.
  - Saturation: if the count reaches 2^CNT_W-1 while echo_s=1, go to DONE with du all-ones and du_timeout=1.
- DONE:
  - du_valid=1; du and du_timeout stay stable.
  - du_ack=1 goes to IDLE next cycle and du_valid drops.
  - du and du_timeout hold their last value until the next TRIG entry.
  - start is ignored in DONE, including a start in the same cycle as du_ack.
- Illegal state encodings go to IDLE.
- Arithmetic:
  - The duration count is CNT_W bits and saturating; it never wraps.
  - The timeout counter is $clog2(TIMEOUT+1) bits.
  - The prescaler is $clog2(PRESCALE) bits, minimum 1.
- Latency:
  - From start to trig high: 1 cycle.
  - From echo falling at the pin to du_valid: 3–4 cycles (synchroniser plus capture).

Test Plan:
- Reset values: hold rst mid-TRIG, TRIG_CYCLES=10 -> trig drops with no clock edge; after release busy=0, du=0, du_valid=0, du_timeout=0.
- Basic measure: PRESCALE=1, TRIG_CYCLES=10, start, echo high for 100 clk after trig ends -> trig high exactly 10 cycles; du=100, du_timeout=0, du_valid stays high until du_ack, then IDLE and busy=0.
- Prescale floor: PRESCALE=4, echo high 10 cycles -> du=2; echo high 12 cycles -> du=3.
- Timeout: TIMEOUT=50, echo held low -> du_valid exactly 50 cycles after WAIT_RISE entry (+1 registration); du=0, du_timeout=1.
- Stale echo and saturation:
  - Echo already high before WAIT_RISE, falls, then rises for 20 cycles -> du=20.
  - CNT_W=4, echo high 40 cycles -> du=15, du_timeout=1.
- Handshake corners: start in TRIG/MEASURE/DONE, and start together with du_ack -> ignored, no new trig; start one cycle after du_ack -> new measurement, du cleared on TRIG entry.

Source files
------------

// File: rtl/echo_timer.sv
// echo_timer: single-channel ultrasonic ranging engine.
// Issues a trigger pulse, waits for a qualified echo rising edge and measures
// the synchronised echo high time in prescaled ticks. The result is held with
// a valid/ack handshake until the consumer accepts it.
//
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   start      - one-cycle measurement request, honoured only in IDLE
//   echo       - raw asynchronous echo from the sensor
//   trig       - registered trigger pulse to the sensor
//   busy       - high whenever the engine is not IDLE
//   du         - measured duration in ticks, held while du_valid
//   du_timeout - du qualifier: no echo edge seen, or counter saturated
//   du_valid   - result available (DONE)
//   du_ack     - consumer accepts the result
module echo_timer #(
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned TRIG_CYCLES = 1000,
  parameter int unsigned PRESCALE    = 1,
  parameter int unsigned TIMEOUT     = 2500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             echo,
  output logic             trig,
  output logic             busy,
  output logic [CNT_W-1:0] du,
  output logic             du_timeout,
  output logic             du_valid,
  input  logic             du_ack
);

  localparam int unsigned TRIG_W = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned PSC_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [PSC_W-1:0]  PSC_LAST  = PSC_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TRIG = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_MEAS = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic              sync1_q, echo_s_q, echo_d_q;
  logic              rise;
  logic [2:0]        state_q, state_d;
  logic [TRIG_W-1:0] trig_cnt_q, trig_cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [PSC_W-1:0]  psc_q, psc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  du_q, du_d;
  logic              du_to_q, du_to_d;
  logic              trig_q, busy_q, valid_q;

  logic              psc_wrap;
  logic [PSC_W-1:0]  psc_adv;
  logic [CNT_W-1:0]  cnt_adv;
  logic              cnt_sat;

  // Two-flop synchroniser plus one delay flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      echo_s_q <= 1'b0;
      echo_d_q <= 1'b0;
    end else begin
      sync1_q  <= echo;
      echo_s_q <= sync1_q;
      echo_d_q <= echo_s_q;
    end
  end

  assign rise = echo_s_q & ~echo_d_q;

  // One high cycle worth of prescaler/duration advance; the count never wraps.
  assign psc_wrap = (psc_q == PSC_LAST);
  assign psc_adv  = psc_wrap ? PSC_W'(0) : psc_q + PSC_W'(1);
  assign cnt_adv  = (psc_wrap && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;
  assign cnt_sat  = psc_wrap && (cnt_adv == CNT_MAX);

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    trig_cnt_d = trig_cnt_q;
    tmo_d      = tmo_q;
    psc_d      = psc_q;
    cnt_d      = cnt_q;
    du_d       = du_q;
    du_to_d    = du_to_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_TRIG;
          trig_cnt_d = '0;
          tmo_d      = '0;
          psc_d      = '0;
          cnt_d      = '0;
          du_d       = '0;
          du_to_d    = 1'b0;
        end
      end
      S_TRIG: begin
        if (trig_cnt_q == TRIG_LAST) begin
          state_d = S_WAIT;
        end else begin
          trig_cnt_d = trig_cnt_q + TRIG_W'(1);
        end
      end
      S_WAIT: begin
        // The rise cycle is the first high cycle; rise beats the timeout.
        if (rise) begin
          psc_d = psc_adv;
          cnt_d = cnt_adv;
          if (cnt_sat) begin
            state_d = S_DONE;
            du_d    = CNT_MAX;
            du_to_d = 1'b1;
          end else begin
            state_d = S_MEAS;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_DONE;
          du_d    = '0;
          du_to_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_MEAS: begin
        if (echo_s_q) begin
          psc_d = psc_adv;
          cnt_d = cnt_adv;
          if (cnt_sat) begin
            state_d = S_DONE;
            du_d    = CNT_MAX;
            du_to_d = 1'b1;
          end
        end else begin
          state_d = S_DONE;
          du_d    = cnt_q;
          du_to_d = 1'b0;
        end
      end
      S_DONE: begin
        if (du_ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs (outputs track the next state).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      trig_cnt_q <= '0;
      tmo_q      <= '0;
      psc_q      <= '0;
      cnt_q      <= '0;
      du_q       <= '0;
      du_to_q    <= 1'b0;
      trig_q     <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      trig_cnt_q <= trig_cnt_d;
      tmo_q      <= tmo_d;
      psc_q      <= psc_d;
      cnt_q      <= cnt_d;
      du_q       <= du_d;
      du_to_q    <= du_to_d;
      trig_q     <= (state_d == S_TRIG);
      busy_q     <= (state_d != S_IDLE);
      valid_q    <= (state_d == S_DONE);
    end
  end

  assign trig       = trig_q;
  assign busy       = busy_q;
  assign du         = du_q;
  assign du_timeout = du_to_q;
  assign du_valid   = valid_q;

endmodule

// File: tb/tb_echo_timer.sv
// Bench for echo_timer: two instances share stimulus.
//   A: CNT_W=8, PRESCALE=1; B: CNT_W=4, PRESCALE=4; both TRIG_CYCLES=10, TIMEOUT=50.
module tb_echo_timer;

  localparam int TRIG_N = 10;
  localparam int TMO_N  = 50;

  logic       clk, rst, start, echo, du_ack;
  logic       trig_a, busy_a, to_a, valid_a;
  logic       trig_b, busy_b, to_b, valid_b;
  logic [7:0] du_a;
  logic [3:0] du_b;

  int n_cmp = 0;
  int n_err = 0;
  int cur_id = 0;

  echo_timer #(.CNT_W(8), .TRIG_CYCLES(TRIG_N), .PRESCALE(1), .TIMEOUT(TMO_N)) u_a (
    .clk(clk), .rst(rst), .start(start), .echo(echo), .trig(trig_a), .busy(busy_a),
    .du(du_a), .du_timeout(to_a), .du_valid(valid_a), .du_ack(du_ack));

  echo_timer #(.CNT_W(4), .TRIG_CYCLES(TRIG_N), .PRESCALE(4), .TIMEOUT(TMO_N)) u_b (
    .clk(clk), .rst(rst), .start(start), .echo(echo), .trig(trig_b), .busy(busy_b),
    .du(du_b), .du_timeout(to_b), .du_valid(valid_b), .du_ack(du_ack));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int high;
    bit stale;
    int du_a;
    int to_a;
    int du_b;
    int to_b;
  } vec_t;

  // Reference: ticks = floor(H / P); reaching the all-ones value saturates.
  function automatic int ref_du(input int h, input int p, input int w);
    int t, mx;
    t  = h / p;
    mx = (1 << w) - 1;
    return (t >= mx) ? mx : t;
  endfunction

  function automatic int ref_to(input int h, input int p, input int w);
    return ((h / p) >= ((1 << w) - 1)) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s (case %0d): got %0d, expected %0d", name, cur_id, act, exp);
    end
  endtask

  // Return both instances to IDLE.
  task automatic settle();
    echo = 1'b0; start = 1'b0; du_ack = 1'b1;
    for (int i = 0; i < 150 && (busy_a || busy_b); i++) @(negedge clk);
    du_ack = 1'b0;
    check("settle_idle", int'(busy_a || busy_b), 0);
  endtask

  // Start a measurement and verify the trigger width; optional start poke in TRIG.
  task automatic do_trigger(input bit poke);
    int tw_a, tw_b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tw_a = 0; tw_b = 0;
    for (int i = 0; i < 40; i++) begin
      if (!trig_a && !trig_b) break;
      if (trig_a) tw_a++;
      if (trig_b) tw_b++;
      start = poke && (i == 3);
      @(negedge clk);
    end
    start = 1'b0;
    check("trig_width_a", tw_a, TRIG_N);
    check("trig_width_b", tw_b, TRIG_N);
  endtask

  task automatic run_meas(input int high, input bit stale, input bit poke,
                          input int e_du_a, input int e_to_a, input int e_du_b, input int e_to_b);
    int gap, kk, k_a;
    settle();
    echo = stale;
    do_trigger(poke);
    if (stale) begin
      repeat (5) @(negedge clk);
      echo = 1'b0;
      repeat (5) @(negedge clk);
    end else begin
      echo = 1'b0;
      gap = $urandom_range(1, 5);
      repeat (gap) @(negedge clk);
    end
    echo = 1'b1;
    for (int i = 0; i < high; i++) begin
      start = poke && (high >= 8) && (i == high / 2);
      @(negedge clk);
    end
    start = 1'b0;
    echo = 1'b0;
    kk = 0; k_a = -1;
    while (!(valid_a && valid_b) && kk < 400) begin
      if (valid_a && k_a < 0) k_a = kk;
      @(negedge clk);
      kk++;
    end
    if (valid_a && k_a < 0) k_a = kk;
    check("valid_seen", int'(valid_a && valid_b), 1);
    if (e_to_a == 0) check("fall_to_valid_a", k_a, 3);
    repeat (3) @(negedge clk);
    check("du_a", int'(du_a), e_du_a);
    check("to_a", int'(to_a), e_to_a);
    check("du_b", int'(du_b), e_du_b);
    check("to_b", int'(to_b), e_to_b);
    check("valid_held", int'(valid_a && valid_b), 1);
    if (poke) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("done_start_no_trig", int'(trig_a || trig_b), 0);
      check("done_start_valid", int'(valid_a && valid_b), 1);
    end
    du_ack = 1'b1;
    start  = poke;
    @(negedge clk);
    du_ack = 1'b0;
    start  = 1'b0;
    check("ack_valid_drop", int'(valid_a || valid_b), 0);
    check("ack_idle", int'(busy_a || busy_b), 0);
    @(negedge clk);
    check("ack_start_ignored", int'(trig_a || trig_b || busy_a), 0);
  endtask

  vec_t vecs[$];

  initial begin
    int k, h;
    bit st;
    rst = 1'b1; start = 1'b0; echo = 1'b0; du_ack = 1'b0;

    vecs.push_back('{100, 1'b0, 100, 0, 15, 1});
    vecs.push_back('{ 10, 1'b0,  10, 0,  2, 0});
    vecs.push_back('{ 12, 1'b0,  12, 0,  3, 0});
    vecs.push_back('{ 20, 1'b1,  20, 0,  5, 0});
    vecs.push_back('{ 40, 1'b0,  40, 0, 10, 0});
    vecs.push_back('{ 59, 1'b0,  59, 0, 14, 0});
    vecs.push_back('{ 60, 1'b0,  60, 0, 15, 1});
    vecs.push_back('{254, 1'b0, 254, 0, 15, 1});
    vecs.push_back('{255, 1'b0, 255, 1, 15, 1});
    vecs.push_back('{300, 1'b0, 255, 1, 15, 1});
    vecs.push_back('{  3, 1'b0,   3, 0,  0, 0});
    vecs.push_back('{  1, 1'b0,   1, 0,  0, 0});

    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy_a || busy_b), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_du", int'(du_a) + int'(du_b), 0);
    check("post_rst_flags", int'(valid_a || to_a || trig_a || valid_b || to_b), 0);

    // Directed table, with handshake pokes on alternating entries.
    foreach (vecs[i]) begin
      cur_id = i;
      run_meas(vecs[i].high, vecs[i].stale, i[0], vecs[i].du_a, vecs[i].to_a,
               vecs[i].du_b, vecs[i].to_b);
    end

    // No echo: timeout exactly TMO_N cycles after WAIT_RISE entry.
    cur_id = 100;
    settle();
    do_trigger(1'b0);
    k = 0;
    while (!valid_a && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("timeout_cycles", k, TMO_N);
    check("timeout_valid_b", int'(valid_b), 1);
    check("timeout_du", int'(du_a) + int'(du_b), 0);
    check("timeout_flag", int'(to_a && to_b), 1);
    du_ack = 1'b1;
    @(negedge clk);
    du_ack = 1'b0;
    check("timeout_ack_idle", int'(busy_a || busy_b), 0);

    // Start one cycle after ack begins a new measurement and clears du.
    cur_id = 101;
    run_meas(30, 1'b0, 1'b0, 30, 0, 7, 0);
    settle();
    do_trigger(1'b0);
    echo = 1'b0;
    repeat (2) @(negedge clk);
    echo = 1'b1;
    repeat (30) @(negedge clk);
    echo = 1'b0;
    k = 0;
    while (!(valid_a && valid_b) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("pre_restart_du_a", int'(du_a), 30);
    du_ack = 1'b1;
    @(negedge clk);
    du_ack = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_trig", int'(trig_a && trig_b && busy_a), 1);
    check("restart_du_clr", int'(du_a) + int'(du_b), 0);
    check("restart_flags", int'(to_a || to_b || valid_a || valid_b), 0);

    // Reset asserted mid-TRIG drops trig without a clock edge.
    cur_id = 102;
    settle();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_trig", int'(trig_a), 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_trig", int'(trig_a || trig_b), 0);
    check("async_rst_busy", int'(busy_a || busy_b), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rel_state", int'(busy_a || valid_a || to_a || trig_a), 0);
    check("rst_rel_du", int'(du_a), 0);

    // Randomised lengths against the arithmetic reference.
    for (int r = 0; r < 20; r++) begin
      cur_id = 200 + r;
      h  = $urandom_range(1, 300);
      st = 1'($urandom_range(0, 1));
      run_meas(h, st, 1'($urandom_range(0, 1)), ref_du(h, 1, 8), ref_to(h, 1, 8),
               ref_du(h, 4, 4), ref_to(h, 4, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
